raw_row3_buffer: RTL and testbench

RAW_ROW3_BUFFER -- requirements
Module: raw_row3_buffer

---
 rtl/raw_row3_buffer.sv | 195 +++++++++++++++++++
 tb/tb_raw_row3_buffer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/raw_row3_buffer.sv
// -----------------------------------------------------------------------------
// raw_row3_buffer
//
// Three-row vertical window for a raw pixel stream that carries 4 packed
// pixels per beat. Each incoming beat leaves the block one cycle later. It is
// presented alongside the beats at the same horizontal position from the two
// previous lines. Those two lines are held in line memories LB1 (y-1) and
// LB0 (y-2).
//
// The rows above the first line of a frame do not exist. A small FSM tracks
// where the current beat sits in the frame: LINE0, LINE1 or STEADY. This
// state selects edge data for the rows that are not yet valid, so memory
// contents from an earlier frame, or from before a reset, never appear on
// the outputs.
//
// Optional feature (macro RAW_ROW3_EDGE_REPLICATE_EN):
//   defined   -> edge rows replicate the nearest real line
//                (LINE0: row1 = row0 = current beat, LINE1: row0 = LB1 beat)
//   undefined -> edge rows are driven as all zeros
//
// Parameters:
//   IMG_WIDTH  pixels per line (line depth BEATS = IMG_WIDTH/4)
//   DATA_WIDTH beat width (4 packed pixels)
//
// Ports:
//   I_clk                       clock, rising edge
//   I_rst                       synchronous active-high reset
//   I_tvalid/I_tuser/I_tlast    beat valid, start of frame, end of line
//   I_tdata                     current-line beat
//   O_tvalid/O_tuser/O_tlast    input sideband delayed by one cycle
//   O_row2                      line y   at the same beat index
//   O_row1                      line y-1 at the same beat index
//   O_row0                      line y-2 at the same beat index
// -----------------------------------------------------------------------------
module raw_row3_buffer #(
    parameter int IMG_WIDTH  = 640,
    parameter int DATA_WIDTH = 96
) (
    input  logic                  I_clk,
    input  logic                  I_rst,
    input  logic                  I_tvalid,
    input  logic                  I_tuser,
    input  logic                  I_tlast,
    input  logic [DATA_WIDTH-1:0] I_tdata,
    output logic                  O_tvalid,
    output logic                  O_tuser,
    output logic                  O_tlast,
    output logic [DATA_WIDTH-1:0] O_row2,
    output logic [DATA_WIDTH-1:0] O_row1,
    output logic [DATA_WIDTH-1:0] O_row0
);

    localparam int          BEATS  = IMG_WIDTH >> 2;
    localparam int          AW     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [10:0] LAST_A = 11'(BEATS - 1);

    typedef enum logic [1:0] {
        LINE0  = 2'd0,
        LINE1  = 2'd1,
        STEADY = 2'd2
    } state_t;

    // Line memories; contents are never cleared.
    logic [DATA_WIDTH-1:0] lb1_mem [0:BEATS-1];
    logic [DATA_WIDTH-1:0] lb0_mem [0:BEATS-1];

    state_t                state_reg, state_next;
    state_t                mask_reg,  mask_next;
    logic                  sync_reg,  sync_next;
    logic [10:0]           wa_reg,    wa_next;
    logic [10:0]           a_eff;
    logic [AW-1:0]         a_idx;

    logic                  tvalid_reg, tuser_reg, tlast_reg;
    logic [DATA_WIDTH-1:0] row2_reg, rd1_reg, rd0_reg;

    // -------------------------------------------------------------------------
    // Address and frame-position logic. A start-of-frame beat is handled
    // before anything else: it forces address 0 and LINE0 masking for the
    // beat itself. sync_reg is cleared by reset and set by the first tuser.
    // Until it is set, end-of-line beats do not advance the state, so a
    // partially received frame stays masked as LINE0.
    // -------------------------------------------------------------------------
    always_comb begin
        a_eff      = I_tuser ? 11'd0 : wa_reg;
        a_idx      = AW'(a_eff);
        mask_next  = I_tuser ? LINE0 : state_reg;
        state_next = state_reg;
        sync_next  = sync_reg;
        wa_next    = wa_reg;

        if (I_tvalid) begin
            if (I_tlast || (a_eff == LAST_A)) begin
                wa_next = 11'd0;
            end else begin
                wa_next = a_eff + 11'd1;
            end

            if (I_tuser) begin
                sync_next = 1'b1;
                // A one-beat line still counts as line 0 of the frame.
                state_next = I_tlast ? LINE1 : LINE0;
            end else if (sync_reg && I_tlast) begin
                case (state_reg)
                    LINE0:   state_next = LINE1;
                    LINE1:   state_next = STEADY;
                    default: state_next = state_reg;
                endcase
            end
        end
    end

    // -------------------------------------------------------------------------
    // Line memory update (read-before-write): LB1 takes the new beat, and
    // LB0 takes what LB1 held at that address, so each line moves down one
    // row per line period.
    // -------------------------------------------------------------------------
    always_ff @(posedge I_clk) begin
        if (I_tvalid) begin
            lb1_mem[a_idx] <= I_tdata;
            lb0_mem[a_idx] <= lb1_mem[a_idx];
        end
    end

    // -------------------------------------------------------------------------
    // Control, sideband and registered memory reads. The row registers and
    // the mask state change only on beats, so the outputs hold their values
    // during gaps in I_tvalid.
    // -------------------------------------------------------------------------
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_reg  <= LINE0;
            mask_reg   <= LINE0;
            sync_reg   <= 1'b0;
            wa_reg     <= 11'd0;
            tvalid_reg <= 1'b0;
            tuser_reg  <= 1'b0;
            tlast_reg  <= 1'b0;
            row2_reg   <= '0;
            rd1_reg    <= '0;
            rd0_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            sync_reg   <= sync_next;
            wa_reg     <= wa_next;
            tvalid_reg <= I_tvalid;
            tuser_reg  <= I_tuser;
            tlast_reg  <= I_tlast;
            if (I_tvalid) begin
                mask_reg <= mask_next;
                row2_reg <= I_tdata;
                rd1_reg  <= lb1_mem[a_idx];
                rd0_reg  <= lb0_mem[a_idx];
            end
        end
    end

    assign O_tvalid = tvalid_reg;
    assign O_tuser  = tuser_reg;
    assign O_tlast  = tlast_reg;
    assign O_row2   = row2_reg;

    // -------------------------------------------------------------------------
    // Row selection. The masking state belongs to the beat now on the
    // outputs. It is not the state of the beat now arriving.
    // -------------------------------------------------------------------------
    always_comb begin
        O_row1 = rd1_reg;
        O_row0 = rd0_reg;
        case (mask_reg)
            LINE0: begin
`ifdef RAW_ROW3_EDGE_REPLICATE_EN
                O_row1 = row2_reg;
                O_row0 = row2_reg;
`else
                O_row1 = '0;
                O_row0 = '0;
`endif
            end
            LINE1: begin
                O_row1 = rd1_reg;
`ifdef RAW_ROW3_EDGE_REPLICATE_EN
                O_row0 = rd1_reg;
`else
                O_row0 = '0;
`endif
            end
            default: begin
                O_row1 = rd1_reg;
                O_row0 = rd0_reg;
            end
        endcase
    end

endmodule

// File: tb/tb_raw_row3_buffer.sv
// -----------------------------------------------------------------------------
// Testbench for raw_row3_buffer with IMG_WIDTH=16 (4 beats per line) and
// DATA_WIDTH=96. A beat of line L at index b carries {48'(L), 48'(b)}.
// The expected edge rows follow RAW_ROW3_EDGE_REPLICATE_EN, so the bench is
// valid whether or not that macro is defined.
// -----------------------------------------------------------------------------
module tb_raw_row3_buffer;

    localparam int IMG_WIDTH  = 16;
    localparam int DATA_WIDTH = 96;
    localparam int BEATS      = IMG_WIDTH >> 2;

    logic                  I_clk;
    logic                  I_rst;
    logic                  I_tvalid;
    logic                  I_tuser;
    logic                  I_tlast;
    logic [DATA_WIDTH-1:0] I_tdata;
    logic                  O_tvalid;
    logic                  O_tuser;
    logic                  O_tlast;
    logic [DATA_WIDTH-1:0] O_row2;
    logic [DATA_WIDTH-1:0] O_row1;
    logic [DATA_WIDTH-1:0] O_row0;

    int compared   = 0;
    int mismatched = 0;

    raw_row3_buffer #(
        .IMG_WIDTH (IMG_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) dut (
        .I_clk   (I_clk),
        .I_rst   (I_rst),
        .I_tvalid(I_tvalid),
        .I_tuser (I_tuser),
        .I_tlast (I_tlast),
        .I_tdata (I_tdata),
        .O_tvalid(O_tvalid),
        .O_tuser (O_tuser),
        .O_tlast (O_tlast),
        .O_row2  (O_row2),
        .O_row1  (O_row1),
        .O_row0  (O_row0)
    );

    initial I_clk = 1'b0;
    always #5 I_clk = ~I_clk;

    function automatic logic [DATA_WIDTH-1:0] pix(input int line, input int beat);
        return {48'(line), 48'(beat)};
    endfunction

    // Value expected on a row that lies above the top of the frame.
    function automatic logic [DATA_WIDTH-1:0] edge_of(input logic [DATA_WIDTH-1:0] d);
`ifdef RAW_ROW3_EDGE_REPLICATE_EN
        return d;
`else
        return '0;
`endif
    endfunction

    // Apply one cycle of input, then sample one time unit after the edge.
    task automatic drive(input logic v, input logic u, input logic l,
                         input logic [DATA_WIDTH-1:0] d);
        I_tvalid = v;
        I_tuser  = u;
        I_tlast  = l;
        I_tdata  = d;
        @(posedge I_clk);
        #1;
        $display("beat v=%0b u=%0b l=%0b d=%h -> ov=%0b ou=%0b ol=%0b r2=%h r1=%h r0=%h",
                 v, u, l, d, O_tvalid, O_tuser, O_tlast, O_row2, O_row1, O_row0);
    endtask

    task automatic test_reset;
        I_rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0);
        drive(1'b1, 1'b1, 1'b1, pix(7, 7));
        compared++;
        if ({O_tvalid, O_tuser, O_tlast} !== 3'b000) begin
            mismatched++;
            $display("FAIL reset_sideband: got %b required 000", {O_tvalid, O_tuser, O_tlast});
        end
        compared++;
        if ({O_row2, O_row1, O_row0} !== {3*DATA_WIDTH{1'b0}}) begin
            mismatched++;
            $display("FAIL reset_rows: got %h/%h/%h required all zero", O_row2, O_row1, O_row0);
        end
        I_rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0);
        compared++;
        if ({O_tvalid, O_row2, O_row1, O_row0} !== {1 + 3*DATA_WIDTH{1'b0}}) begin
            mismatched++;
            $display("FAIL reset_idle: got v=%b %h/%h/%h required all zero",
                     O_tvalid, O_row2, O_row1, O_row0);
        end
    endtask

    // Three complete lines starting with a tuser beat. Lines are numbered
    // base, base+1 and base+2, so the checks cover LINE0, LINE1 and STEADY.
    task automatic run_frame(input int base, input string tag);
        logic [DATA_WIDTH-1:0] e2, e1, e0;
        for (int li = 0; li < 3; li++) begin
            for (int b = 0; b < BEATS; b++) begin
                drive(1'b1, (li == 0 && b == 0), (b == BEATS - 1), pix(base + li, b));
                e2 = pix(base + li, b);
                if (li == 0) begin
                    e1 = edge_of(pix(base, b));
                    e0 = edge_of(pix(base, b));
                end else if (li == 1) begin
                    e1 = pix(base, b);
                    e0 = edge_of(pix(base, b));
                end else begin
                    e1 = pix(base + 1, b);
                    e0 = pix(base, b);
                end
                compared++;
                if ({O_tvalid, O_tuser, O_tlast} !== {1'b1, (li == 0 && b == 0), (b == BEATS - 1)}) begin
                    mismatched++;
                    $display("FAIL %s_sideband line%0d beat%0d: got %b", tag, li, b,
                             {O_tvalid, O_tuser, O_tlast});
                end
                compared++;
                if ({O_row2, O_row1, O_row0} !== {e2, e1, e0}) begin
                    mismatched++;
                    $display("FAIL %s_rows line%0d beat%0d: got %h/%h/%h required %h/%h/%h",
                             tag, li, b, O_row2, O_row1, O_row0, e2, e1, e0);
                end
            end
        end
    endtask

    task automatic test_three_lines;
        run_frame(0, "three_lines");
    endtask

    // Line 3 of the frame, with a gap after every beat. Gap cycles carry
    // junk data, which must not be written to memory or reach the outputs.
    task automatic test_gaps;
        logic [DATA_WIDTH-1:0] e2, e1, e0;
        for (int b = 0; b < BEATS; b++) begin
            drive(1'b1, 1'b0, (b == BEATS - 1), pix(3, b));
            e2 = pix(3, b);
            e1 = pix(2, b);
            e0 = pix(1, b);
            compared++;
            if ({O_tvalid, O_row2, O_row1, O_row0} !== {1'b1, e2, e1, e0}) begin
                mismatched++;
                $display("FAIL gaps_beat%0d: got v=%b %h/%h/%h required v=1 %h/%h/%h",
                         b, O_tvalid, O_row2, O_row1, O_row0, e2, e1, e0);
            end
            drive(1'b0, 1'b0, 1'b0, {DATA_WIDTH{1'b1}});
            compared++;
            if ({O_tvalid, O_row2, O_row1, O_row0} !== {1'b0, e2, e1, e0}) begin
                mismatched++;
                $display("FAIL gaps_hold%0d: got v=%b %h/%h/%h required v=0 %h/%h/%h",
                         b, O_tvalid, O_row2, O_row1, O_row0, e2, e1, e0);
            end
        end
    endtask

    // A tuser arrives on beat 2 of line 4, then the new frame continues.
    task automatic test_restart;
        logic [DATA_WIDTH-1:0] e2, e1, e0;
        for (int b = 0; b < 2; b++) begin
            drive(1'b1, 1'b0, 1'b0, pix(4, b));
            compared++;
            if ({O_row2, O_row1, O_row0} !== {pix(4, b), pix(3, b), pix(2, b)}) begin
                mismatched++;
                $display("FAIL restart_pre%0d: got %h/%h/%h", b, O_row2, O_row1, O_row0);
            end
        end
        // New frame line 9. Its beat 0 arrives where line 4 beat 2 would be.
        for (int b = 0; b < BEATS; b++) begin
            drive(1'b1, (b == 0), (b == BEATS - 1), pix(9, b));
            e2 = pix(9, b);
            e1 = edge_of(pix(9, b));
            e0 = edge_of(pix(9, b));
            compared++;
            if ({O_row2, O_row1, O_row0} !== {e2, e1, e0}) begin
                mismatched++;
                $display("FAIL restart_line0 beat%0d: got %h/%h/%h required %h/%h/%h",
                         b, O_row2, O_row1, O_row0, e2, e1, e0);
            end
        end
        // Line 10 must align with line 9 from address 0.
        for (int b = 0; b < BEATS; b++) begin
            drive(1'b1, 1'b0, (b == BEATS - 1), pix(10, b));
            e2 = pix(10, b);
            e1 = pix(9, b);
            e0 = edge_of(pix(9, b));
            compared++;
            if ({O_row2, O_row1, O_row0} !== {e2, e1, e0}) begin
                mismatched++;
                $display("FAIL restart_line1 beat%0d: got %h/%h/%h required %h/%h/%h",
                         b, O_row2, O_row1, O_row0, e2, e1, e0);
            end
        end
    endtask

    // Reset pulse in the middle of a line. The block then receives tuser-less
    // beats and must stay in LINE0 until the next frame starts.
    task automatic test_reset_midline;
        logic [DATA_WIDTH-1:0] e2;
        for (int b = 0; b < 2; b++) begin
            drive(1'b1, 1'b0, 1'b0, pix(11, b));
            compared++;
            if ({O_row2, O_row1, O_row0} !== {pix(11, b), pix(10, b), pix(9, b)}) begin
                mismatched++;
                $display("FAIL rstmid_pre%0d: got %h/%h/%h", b, O_row2, O_row1, O_row0);
            end
        end
        I_rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0);
        I_rst = 1'b0;
        compared++;
        if ({O_tvalid, O_tuser, O_tlast, O_row2, O_row1, O_row0} !== {3 + 3*DATA_WIDTH{1'b0}}) begin
            mismatched++;
            $display("FAIL rstmid_clear: got v=%b u=%b l=%b %h/%h/%h required all zero",
                     O_tvalid, O_tuser, O_tlast, O_row2, O_row1, O_row0);
        end
        // The rest of line 12, then a full line 13. Neither has a tuser, so
        // both stay in LINE0 even after a tlast.
        for (int k = 0; k < 2 + BEATS; k++) begin
            if (k < 2) e2 = pix(12, k + 2);
            else       e2 = pix(13, k - 2);
            drive(1'b1, 1'b0, (k == 1 || k == 1 + BEATS), e2);
            compared++;
            if ({O_tvalid, O_row2, O_row1, O_row0} !== {1'b1, e2, edge_of(e2), edge_of(e2)}) begin
                mismatched++;
                $display("FAIL rstmid_unsynced%0d: got v=%b %h/%h/%h required %h/%h/%h",
                         k, O_tvalid, O_row2, O_row1, O_row0, e2, edge_of(e2), edge_of(e2));
            end
        end
        run_frame(20, "rstmid_frame");
    endtask

    // tuser and tlast on the same beat give a one-beat line 0. The next line
    // is LINE1, and the line after that is STEADY.
    task automatic test_tuser_tlast;
        logic [DATA_WIDTH-1:0] e0;
        drive(1'b1, 1'b1, 1'b1, pix(30, 0));
        compared++;
        if ({O_tvalid, O_tuser, O_tlast, O_row2, O_row1, O_row0} !==
            {3'b111, pix(30, 0), edge_of(pix(30, 0)), edge_of(pix(30, 0))}) begin
            mismatched++;
            $display("FAIL ut_beat: got v=%b u=%b l=%b %h/%h/%h",
                     O_tvalid, O_tuser, O_tlast, O_row2, O_row1, O_row0);
        end
        for (int b = 0; b < BEATS; b++) begin
            drive(1'b1, 1'b0, (b == BEATS - 1), pix(31, b));
            compared++;
            if (O_row2 !== pix(31, b)) begin
                mismatched++;
                $display("FAIL ut_line1_row2 beat%0d: got %h required %h", b, O_row2, pix(31, b));
            end
            if (b == 0) begin
                compared++;
                if ({O_row1, O_row0} !== {pix(30, 0), edge_of(pix(30, 0))}) begin
                    mismatched++;
                    $display("FAIL ut_line1_addr0: got %h/%h required %h/%h",
                             O_row1, O_row0, pix(30, 0), edge_of(pix(30, 0)));
                end
            end
        end
        // In STEADY, row0 comes from LB0. Address 0 holds line 30. The other
        // addresses still hold line 22 from the previous frame.
        for (int b = 0; b < BEATS; b++) begin
            drive(1'b1, 1'b0, (b == BEATS - 1), pix(32, b));
            e0 = (b == 0) ? pix(30, 0) : pix(22, b);
            compared++;
            if ({O_row2, O_row1, O_row0} !== {pix(32, b), pix(31, b), e0}) begin
                mismatched++;
                $display("FAIL ut_steady beat%0d: got %h/%h/%h required %h/%h/%h",
                         b, O_row2, O_row1, O_row0, pix(32, b), pix(31, b), e0);
            end
        end
    endtask

    initial begin
        I_rst    = 1'b1;
        I_tvalid = 1'b0;
        I_tuser  = 1'b0;
        I_tlast  = 1'b0;
        I_tdata  = '0;
        test_reset;
        test_three_lines;
        test_gaps;
        test_restart;
        test_reset_midline;
        test_tuser_tlast;
        drive(1'b0, 1'b0, 1'b0, '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
